// File: rtl/score_counter_if.sv
// Bus between the score accumulator and its environment.
// master drives the event and clear inputs; slave is the counter and drives the results.
interface score_counter_if;
    logic        clr;
    logic        add_evt;
    logic [3:0]  add_amt;
    logic        sub_evt;
    logic [3:0]  score_0;
    logic [3:0]  score_1;
    logic [3:0]  score_2;
    logic [3:0]  score_3;
    logic [15:0] hi_score;
    logic        busy;
    logic        sat;

    modport master (
        output clr, add_evt, add_amt, sub_evt,
        input  score_0, score_1, score_2, score_3, hi_score, busy, sat
    );

    modport slave (
        input  clr, add_evt, add_amt, sub_evt,
        output score_0, score_1, score_2, score_3, hi_score, busy, sat
    );
endinterface

// File: rtl/score_counter.sv
// score_counter: 4-digit BCD score accumulator with saturation and high-score tracking.
// Arithmetic runs one BCD digit per cycle on a working copy; the visible score only
// changes in CMP, so the display never shows a half-propagated carry or borrow.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for a pending add/sub; add wins when both are pending
//   ADD   | 4 cycles, one digit each (ones first), carry rippled
//   SUB   | 4 cycles, one digit each (ones first), borrow rippled
//   CMP   | commit working value, update hi_score, release the event slot
module score_counter #(
    parameter int unsigned PENALTY   = 1,
    parameter bit          EDGE_ONLY = 1'b1
) (
    input  logic           clk,
    input  logic           reset_n,
    score_counter_if.slave bus
);

    localparam logic [3:0]  PEN_BCD = (PENALTY > 9) ? 4'd9 : 4'(PENALTY);
    localparam logic [15:0] BCD_MAX = 16'h9999;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_SUB  = 2'd2,
        S_CMP  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_add_q;
    logic        r_sub_q;
    logic        w_add_edge;
    logic        w_sub_edge;
    logic        w_add_req;
    logic        w_sub_req;

    logic        r_add_pend;
    logic        r_sub_pend;
    logic        w_add_pend_nxt;
    logic        w_sub_pend_nxt;

    logic [3:0]  w_amt_in;
    logic [3:0]  r_add_amt;
    logic [3:0]  w_add_opnd;

    logic [3:0]  r_opnd;
    logic        r_op_sub;
    logic [15:0] r_work;
    logic [1:0]  r_idx;
    logic        r_cy;

    logic [15:0] r_score;
    logic [15:0] r_hi;
    logic        r_sat;
    logic        r_post;

    logic [3:0]  w_dig_a;
    logic [3:0]  w_dig_b;
    logic [3:0]  w_dig_res;
    logic        w_cy_out;
    logic [4:0]  w_t;

    // Out-of-range addends saturate to a single digit 9.
    assign w_amt_in = (bus.add_amt > 4'd9) ? 4'd9 : bus.add_amt;

    // In level mode the input itself is the request; the slot logic still dedups it.
    assign w_add_edge = EDGE_ONLY ? (bus.add_evt & ~r_add_q) : bus.add_evt;
    assign w_sub_edge = EDGE_ONLY ? (bus.sub_evt & ~r_sub_q) : bus.sub_evt;

    // A fresh edge is usable in IDLE on the same cycle it arrives, which is
    // what puts the first ADD/SUB cycle right after the sampling edge.
    assign w_add_req  = r_add_pend | w_add_edge;
    assign w_sub_req  = r_sub_pend | w_sub_edge;

    // A queued add keeps the amount captured when its edge arrived.
    assign w_add_opnd = r_add_pend ? r_add_amt : w_amt_in;

    // Input history for edge detection; keeps running through clr.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_add_q <= 1'b0;
            r_sub_q <= 1'b0;
        end else begin
            r_add_q <= bus.add_evt;
            r_sub_q <= bus.sub_evt;
        end
    end

    // Event slots: set on edge, edges into an occupied slot are dropped,
    // the consumed slot is released in CMP.
    always_comb begin
        w_add_pend_nxt = r_add_pend | w_add_edge;
        w_sub_pend_nxt = r_sub_pend | w_sub_edge;
        if (r_state == S_CMP) begin
            if (r_op_sub) begin
                w_sub_pend_nxt = 1'b0;
            end else begin
                w_add_pend_nxt = 1'b0;
            end
        end
    end

    // One BCD digit of add or subtract; operand only enters at the ones digit.
    always_comb begin
        w_dig_a   = r_work[{r_idx, 2'b00} +: 4];
        w_dig_b   = (r_idx == 2'd0) ? r_opnd : 4'd0;
        w_t       = 5'd0;
        w_cy_out  = 1'b0;
        if (r_op_sub) begin
            w_t = {1'b0, w_dig_b} + {4'd0, r_cy};
            if ({1'b0, w_dig_a} < w_t) begin
                w_t      = {1'b0, w_dig_a} + 5'd10 - w_t;
                w_cy_out = 1'b1;
            end else begin
                w_t      = {1'b0, w_dig_a} - w_t;
            end
        end else begin
            w_t = {1'b0, w_dig_a} + {1'b0, w_dig_b} + {4'd0, r_cy};
            if (w_t > 5'd9) begin
                w_t      = w_t - 5'd10;
                w_cy_out = 1'b1;
            end
        end
        w_dig_res = w_t[3:0];
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; clr overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_add_req) begin
                    w_state_nxt = S_ADD;
                end else if (w_sub_req) begin
                    w_state_nxt = S_SUB;
                end
            end
            S_ADD, S_SUB: begin
                if (r_idx == 2'd3) begin
                    w_state_nxt = S_CMP;
                end
            end
            S_CMP:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (bus.clr) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Datapath: operand latch, digit-serial working register, commit and high score.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_add_pend <= 1'b0;
            r_sub_pend <= 1'b0;
            r_add_amt  <= 4'd0;
            r_opnd     <= 4'd0;
            r_op_sub   <= 1'b0;
            r_work     <= 16'd0;
            r_idx      <= 2'd0;
            r_cy       <= 1'b0;
            r_score    <= 16'd0;
            r_hi       <= 16'd0;
            r_sat      <= 1'b0;
            r_post     <= 1'b0;
        end else begin
            r_post <= 1'b0;
            if (bus.clr) begin
                r_add_pend <= 1'b0;
                r_sub_pend <= 1'b0;
                r_idx      <= 2'd0;
                r_cy       <= 1'b0;
                r_score    <= 16'd0;
                r_sat      <= 1'b0;
            end else begin
                r_add_pend <= w_add_pend_nxt;
                r_sub_pend <= w_sub_pend_nxt;
                if (w_add_edge && !r_add_pend) begin
                    r_add_amt <= w_amt_in;
                end
                case (r_state)
                    S_IDLE: begin
                        if (w_add_req) begin
                            r_opnd   <= w_add_opnd;
                            r_op_sub <= 1'b0;
                            r_work   <= r_score;
                            r_idx    <= 2'd0;
                            r_cy     <= 1'b0;
                        end else if (w_sub_req) begin
                            r_opnd   <= PEN_BCD;
                            r_op_sub <= 1'b1;
                            r_work   <= r_score;
                            r_idx    <= 2'd0;
                            r_cy     <= 1'b0;
                        end
                    end
                    S_ADD, S_SUB: begin
                        r_work[{r_idx, 2'b00} +: 4] <= w_dig_res;
                        r_cy  <= w_cy_out;
                        r_idx <= r_idx + 2'd1;
                        // Carry/borrow out of the thousands digit clamps the result.
                        if ((r_idx == 2'd3) && w_cy_out) begin
                            if (r_op_sub) begin
                                r_work <= 16'd0;
                            end else begin
                                r_work <= BCD_MAX;
                                r_sat  <= 1'b1;
                            end
                        end
                    end
                    S_CMP: begin
                        r_score <= r_work;
                        // Packed BCD orders the same as binary, so a plain compare works.
                        if (r_work > r_hi) begin
                            r_hi <= r_work;
                        end
                        r_post <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // busy stays up for one cycle past the commit so the operation window covers it.
    assign bus.score_0  = r_score[3:0];
    assign bus.score_1  = r_score[7:4];
    assign bus.score_2  = r_score[11:8];
    assign bus.score_3  = r_score[15:12];
    assign bus.hi_score = r_hi;
    assign bus.busy     = (r_state != S_IDLE) | r_post;
    assign bus.sat      = r_sat;

endmodule
